// File: rtl/operand_select_pipe.sv
// Registered operand selector: one of NUM_IN data inputs or a constant-bank entry, one cycle later, valid/ready.
// Optional feature macro: OPSEL_CONST_WRITE_EN makes the constant bank runtime-writable.
module operand_select_pipe #(
    parameter int WIDTH     = 17,
    parameter int NUM_IN    = 2,
    parameter int NUM_CONST = 3,
    parameter int SEL_W     = 4,
    parameter logic [NUM_CONST*WIDTH-1:0] CONST_INIT = {17'd97, 17'd96, 17'd1}
) (
    input  logic                    Clock,
    input  logic                    ResetN,
    input  logic [NUM_IN*WIDTH-1:0] InputBus,
    input  logic [SEL_W-1:0]        Selection,
    input  logic                    InValid,
    output logic                    InReady,
    output logic [WIDTH-1:0]        Output,
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic                    OutError,
    output logic [7:0]              ErrCount,
    input  logic                    ConstWrEn,
    input  logic [SEL_W-1:0]        ConstWrAddr,
    input  logic [WIDTH-1:0]        ConstWrData
);

    logic [WIDTH-1:0] bank [NUM_CONST];
    logic [WIDTH-1:0] selData;
    logic             selHit;
    logic             accept;

    assign InReady = !OutValid || OutReady;
    assign accept  = InValid && InReady;

`ifdef OPSEL_CONST_WRITE_EN
    // Writes land at the edge, so an accept in the same cycle still decodes the old entry.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            for (int k = 0; k < NUM_CONST; k++) begin
                bank[k] <= CONST_INIT[k*WIDTH +: WIDTH];
            end
        end else if (ConstWrEn) begin
            for (int k = 0; k < NUM_CONST; k++) begin
                if (32'(ConstWrAddr) == k) begin
                    bank[k] <= ConstWrData;
                end
            end
        end
    end
`else
    logic unusedConstWr;
    assign unusedConstWr = ^{ConstWrEn, ConstWrAddr, ConstWrData};

    always_comb begin
        for (int k = 0; k < NUM_CONST; k++) begin
            bank[k] = CONST_INIT[k*WIDTH +: WIDTH];
        end
    end
`endif

    // Codes beyond the data inputs index the constant bank; anything past that is out of range.
    always_comb begin
        selData = '0;
        selHit  = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (32'(Selection) == i) begin
                selData = InputBus[i*WIDTH +: WIDTH];
                selHit  = 1'b1;
            end
        end
        for (int k = 0; k < NUM_CONST; k++) begin
            if (32'(Selection) == NUM_IN + k) begin
                selData = bank[k];
                selHit  = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            Output   <= '0;
            OutValid <= 1'b0;
            OutError <= 1'b0;
            ErrCount <= '0;
        end else begin
            if (accept) begin
                OutValid <= 1'b1;
                if (selHit) begin
                    Output   <= selData;
                    OutError <= 1'b0;
                end else begin
                    OutError <= 1'b1;
                    if (ErrCount != 8'hFF) begin
                        ErrCount <= ErrCount + 8'd1;
                    end
                end
            end else if (OutReady) begin
                OutValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_operand_select_pipe.sv
// Self-checking bench for operand_select_pipe: directed vector table, hand sequences, randomized model check.
// Honours OPSEL_CONST_WRITE_EN the same way the design does.
module tb_operand_select_pipe;

    localparam logic [33:0] BUS_A = {17'h1ABCD, 17'h00055};

    logic        Clock = 1'b0;
    logic        ResetN;
    logic [33:0] InputBus;
    logic [3:0]  Selection;
    logic        InValid;
    logic        InReady;
    logic [16:0] Output;
    logic        OutValid;
    logic        OutReady;
    logic        OutError;
    logic [7:0]  ErrCount;
    logic        ConstWrEn;
    logic [3:0]  ConstWrAddr;
    logic [16:0] ConstWrData;

    int testsRun    = 0;
    int testsFailed = 0;

    logic        modelKnown = 1'b0;
    logic        mValid;
    logic [16:0] mOut;
    logic        mErr;
    logic [7:0]  mCnt;
    logic [16:0] mBank [3];
    logic [21:0] unusedWr;

    typedef struct {
        logic        rn;
        logic        iv;
        logic        orr;
        logic [3:0]  sel;
        logic [16:0] eOut;
        logic        eValid;
        logic        eErr;
        logic [7:0]  eCnt;
    } vec_t;

    vec_t vecs [11];

    always #5 Clock = ~Clock;

    operand_select_pipe dut (
        .Clock(Clock), .ResetN(ResetN), .InputBus(InputBus), .Selection(Selection),
        .InValid(InValid), .InReady(InReady), .Output(Output), .OutValid(OutValid),
        .OutReady(OutReady), .OutError(OutError), .ErrCount(ErrCount),
        .ConstWrEn(ConstWrEn), .ConstWrAddr(ConstWrAddr), .ConstWrData(ConstWrData)
    );

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference behaviour: whatever was accepted this edge shows up right after it.
    task automatic modelStep(input logic rn, iv, orr, input logic [3:0] sel, input logic [33:0] bus,
                             input logic we, input logic [3:0] wa, input logic [16:0] wd);
        int s;
        s = int'(sel);
        if (!rn) begin
            mValid = 1'b0; mOut = '0; mErr = 1'b0; mCnt = '0;
            mBank[0] = 17'd1; mBank[1] = 17'd96; mBank[2] = 17'd97;
            modelKnown = 1'b1;
        end else begin
            if (iv && (!mValid || orr)) begin
                mValid = 1'b1;
                if (s < 2) begin
                    mOut = bus[s*17 +: 17]; mErr = 1'b0;
                end else if (s < 5) begin
                    mOut = mBank[s-2]; mErr = 1'b0;
                end else begin
                    mErr = 1'b1;
                    if (mCnt < 8'd255) mCnt = mCnt + 8'd1;
                end
            end else if (orr) begin
                mValid = 1'b0;
            end
`ifdef OPSEL_CONST_WRITE_EN
            if (we && int'(wa) < 3) mBank[int'(wa)] = wd;
            unusedWr = '0;
`else
            unusedWr = {we, wa, wd};
`endif
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, " Output"},   32'(Output),   32'(mOut));
        checkVal({tag, " OutValid"}, 32'(OutValid), 32'(mValid));
        if (mValid) checkVal({tag, " OutError"}, 32'(OutError), 32'(mErr));
        checkVal({tag, " ErrCount"}, 32'(ErrCount), 32'(mCnt));
    endtask

    task automatic applyStimulus(input logic rn, iv, orr, input logic [3:0] sel, input logic [33:0] bus,
                                 input logic we, input logic [3:0] wa, input logic [16:0] wd);
        ResetN = rn; InValid = iv; OutReady = orr; Selection = sel; InputBus = bus;
        ConstWrEn = we; ConstWrAddr = wa; ConstWrData = wd;
        #1;
        if (modelKnown) checkVal("InReady", 32'(InReady), 32'(!mValid || orr));
        @(posedge Clock);
        modelStep(rn, iv, orr, sel, bus, we, wa, wd);
        #1;
    endtask

    task automatic checkConst(input string tag, input logic [16:0] eOut, input logic eValid,
                              input logic eErr, input logic [7:0] eCnt);
        checkVal({tag, " Output"},   32'(Output),   32'(eOut));
        checkVal({tag, " OutValid"}, 32'(OutValid), 32'(eValid));
        checkVal({tag, " OutError"}, 32'(OutError), 32'(eErr));
        checkVal({tag, " ErrCount"}, 32'(ErrCount), 32'(eCnt));
    endtask

    initial begin
        logic [16:0] afterWrite;
`ifdef OPSEL_CONST_WRITE_EN
        afterWrite = 17'd500;
`else
        afterWrite = 17'd96;
`endif
        //             rn    iv    orr   sel    eOut        eValid eErr  eCnt
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 4'd0, 17'h00000, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 4'd0, 17'h00000, 1'b0, 1'b0, 8'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 4'd0, 17'h00055, 1'b1, 1'b0, 8'd0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 4'd1, 17'h1ABCD, 1'b1, 1'b0, 8'd0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 4'd2, 17'd1,     1'b1, 1'b0, 8'd0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 4'd3, 17'd96,    1'b1, 1'b0, 8'd0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 4'd4, 17'd97,    1'b1, 1'b0, 8'd0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 4'd3, 17'd96,    1'b1, 1'b0, 8'd0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 4'd9, 17'd96,    1'b1, 1'b1, 8'd1};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 4'd0, 17'h00055, 1'b1, 1'b0, 8'd1};
        vecs[10] = '{1'b0 | 1'b1, 1'b0, 1'b1, 4'd0, 17'h00055, 1'b0, 1'b0, 8'd1};

        for (int v = 0; v < 11; v++) begin
            applyStimulus(vecs[v].rn, vecs[v].iv, vecs[v].orr, vecs[v].sel, BUS_A, 1'b0, 4'd0, 17'd0);
            checkConst($sformatf("vec%0d", v), vecs[v].eOut, vecs[v].eValid, vecs[v].eErr, vecs[v].eCnt);
            checkOutput($sformatf("vec%0d model", v));
        end

        // Stall: held beat must not follow InputBus, and nothing new is accepted.
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd1, BUS_A, 1'b0, 4'd0, 17'd0);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, {$urandom, $urandom}, 1'b0, 4'd0, 17'd0);
            checkVal("stall InReady", 32'(InReady), 32'd0);
            checkConst("stall", 17'h1ABCD, 1'b1, 1'b0, 8'd1);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd0, BUS_A, 1'b0, 4'd0, 17'd0);
        checkConst("drain", 17'h00055, 1'b1, 1'b0, 8'd1);

        // Error counter saturation.
        for (int c = 0; c < 300; c++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 4'($urandom_range(15, 5)), {$urandom, $urandom}, 1'b0, 4'd0, 17'd0);
        end
        checkConst("saturate", 17'h00055, 1'b1, 1'b1, 8'd255);

        // Constant bank write versus same-cycle read.
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd3, BUS_A, 1'b1, 4'd1, 17'd500);
        checkConst("wr same", 17'd96, 1'b1, 1'b0, 8'd255);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd3, BUS_A, 1'b0, 4'd0, 17'd0);
        checkConst("wr next", afterWrite, 1'b1, 1'b0, 8'd255);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd2, BUS_A, 1'b1, 4'd7, 17'd123);
        checkConst("wr oob c0", 17'd1, 1'b1, 1'b0, 8'd255);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd3, BUS_A, 1'b0, 4'd0, 17'd0);
        checkConst("wr oob c1", afterWrite, 1'b1, 1'b0, 8'd255);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd4, BUS_A, 1'b0, 4'd0, 17'd0);
        checkConst("wr oob c2", 17'd97, 1'b1, 1'b0, 8'd255);

        // Reset while a beat is stalled.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, BUS_A, 1'b0, 4'd0, 17'd0);
        checkConst("pre-reset", 17'd97, 1'b1, 1'b0, 8'd255);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, BUS_A, 1'b0, 4'd0, 17'd0);
        checkConst("mid reset", 17'd0, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd3, BUS_A, 1'b0, 4'd0, 17'd0);
        checkConst("bank restored", 17'd96, 1'b1, 1'b0, 8'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            applyStimulus(1'($urandom_range(99) != 0), 1'($urandom_range(1)), 1'($urandom_range(3) != 0),
                          4'($urandom_range(7)), {$urandom, $urandom}, 1'($urandom_range(3) == 0),
                          4'($urandom_range(4)), 17'($urandom));
            checkOutput($sformatf("rand%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
